caster_bus_dispatcher: RTL and testbench

Bus-side driver for one row of PE casters. It accepts tagged data packets from the upstream input buffer over a valid/ready stream and owns the per-column caster ID table. It drives the shared row bus (tag, enable, data) so that a packet is delivered in a single cycle to every caster whose ID equals the packet tag, and only when all of those targets report ready. It sits directly upstream of the casters; their ready outputs return to this block.

---
 rtl/caster_pkg.sv | 21 ++
 rtl/caster_id_table.sv | 57 +++++
 rtl/caster_bus_dispatcher.sv | 188 ++++++++++++++++++
 tb/tb_caster_bus_dispatcher.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/caster_pkg.sv
// Shared types and constants for the caster row bus dispatcher.
//   dispatch_state_e : dispatcher FSM states
//   tag_t / data_t   : tag and payload types at the default row geometry
//   PKT_CNT_W        : width of the delivered-packet counter
package caster_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int NUM_COL_DEF    = 4;
    localparam int TAG_W_DEF      = $clog2(NUM_COL_DEF);
    localparam int PKT_CNT_W      = 16;

    typedef logic [TAG_W_DEF-1:0]      tag_t;
    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SETTLE = 2'd2
    } dispatch_state_e;

endpackage

// File: rtl/caster_id_table.sv
// Per-column caster ID register file with write decode and match-mask generation.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset (table reverts to identity)
//   we          : write strobe (already qualified by the caller's handshake)
//   col, id_in  : column to program and its new ID
//   match_tag   : tag compared against every column's ID
//   id_out      : packed IDs, column c at [c*TAG_W +: TAG_W]
//   mask        : mask[c] = (id[c] == match_tag)
//   col_ok      : col addresses an existing column
module caster_id_table
    import caster_pkg::*;
#(
    parameter int NUM_COL = NUM_COL_DEF,
    parameter int TAG_W   = $clog2(NUM_COL)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     we,
    input  logic [TAG_W-1:0]         col,
    input  logic [TAG_W-1:0]         id_in,
    input  logic [TAG_W-1:0]         match_tag,
    output logic [NUM_COL*TAG_W-1:0] id_out,
    output logic [NUM_COL-1:0]       mask,
    output logic                     col_ok
);

    localparam logic [TAG_W:0] NUM_COL_L = (TAG_W+1)'(NUM_COL);

    logic [TAG_W-1:0] id_r [NUM_COL];

    // Out-of-range columns can only exist when NUM_COL is not a power of two.
    assign col_ok = ({1'b0, col} < NUM_COL_L);

    // ID register file; reset restores the identity mapping id[c] = c.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_COL; c++) begin
                id_r[c] <= TAG_W'(c);
            end
        end else if (we && col_ok) begin
            id_r[col] <= id_in;
        end else begin
            id_r <= id_r;
        end
    end

    // Flatten the table and compare every entry against the bus tag.
    always_comb begin
        id_out = '0;
        mask   = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            id_out[c*TAG_W +: TAG_W] = id_r[c];
            mask[c]                  = (id_r[c] == match_tag);
        end
    end

endmodule

// File: rtl/caster_bus_dispatcher.sv
// Drives one row of PE casters: holds one tagged packet and broadcasts it on the
// row bus in a single cycle once every caster whose ID matches the tag is ready.
// Ports:
//   clk, rstn                  : clock, asynchronous active-low reset
//   s_valid/s_ready/s_tag/s_data : upstream packet stream
//   cfg_we/cfg_col/cfg_id/cfg_ready : ID table programming
//   id_out                     : current per-column IDs
//   caster_ready               : per-column readiness from the casters
//   bus_en/bus_tag/bus_data    : shared row bus
//   drop_pulse                 : packet discarded (no column matched)
//   stall_err/err_clr          : sticky timeout flag and its clear
//   pkt_cnt                    : delivered-packet counter (wraps)
module caster_bus_dispatcher
    import caster_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_COL    = NUM_COL_DEF,
    parameter int TAG_W      = $clog2(NUM_COL),
    parameter int TIMEOUT    = 1024
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [TAG_W-1:0]         s_tag,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     cfg_we,
    input  logic [TAG_W-1:0]         cfg_col,
    input  logic [TAG_W-1:0]         cfg_id,
    output logic                     cfg_ready,
    output logic [NUM_COL*TAG_W-1:0] id_out,
    input  logic [NUM_COL-1:0]       caster_ready,
    output logic                     bus_en,
    output logic [TAG_W-1:0]         bus_tag,
    output logic [DATA_WIDTH-1:0]    bus_data,
    output logic                     drop_pulse,
    output logic                     stall_err,
    input  logic                     err_clr,
    output logic [PKT_CNT_W-1:0]     pkt_cnt
);

    // Counter saturates at TIMEOUT so the stall flag is raised exactly once per stall.
    localparam int               WC_W      = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0]  WAIT_MAX  = WC_W'(TIMEOUT);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(TIMEOUT - 1);

    dispatch_state_e         state_r, state_nxt_s;
    logic [TAG_W-1:0]        bus_tag_r;
    logic [DATA_WIDTH-1:0]   bus_data_r;
    logic [WC_W-1:0]         wait_cnt_r;
    logic                    stall_err_r;
    logic [PKT_CNT_W-1:0]    pkt_cnt_r;
    logic                    drop_pulse_r;

    logic                    hold_valid_s;
    logic [NUM_COL-1:0]      mask_s;
    logic                    col_ok_s;
    logic                    fire_s;
    logic                    drop_s;
    logic                    s_ready_s;
    logic                    cfg_ready_s;
    logic                    accept_s;

    caster_id_table #(
        .NUM_COL (NUM_COL),
        .TAG_W   (TAG_W)
    ) u_id_table (
        .clk       (clk),
        .rstn      (rstn),
        .we        (cfg_we & cfg_ready_s),
        .col       (cfg_col),
        .id_in     (cfg_id),
        .match_tag (bus_tag_r),
        .id_out    (id_out),
        .mask      (mask_s),
        .col_ok    (col_ok_s)
    );

    assign hold_valid_s = (state_r == HOLD);
    // Transfer only when every targeted caster is ready, so no partial multicast.
    assign fire_s   = hold_valid_s & (|mask_s) & (&(caster_ready | ~mask_s));
    assign drop_s   = hold_valid_s & ~(|mask_s);
    assign accept_s = s_valid & s_ready_s;

    // Next-state and handshake decode; a config write wins over a packet in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        s_ready_s   = 1'b0;
        cfg_ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                cfg_ready_s = 1'b1;
                s_ready_s   = ~cfg_we;
                if (cfg_we && col_ok_s) begin
                    state_nxt_s = SETTLE;
                end else if (s_valid && !cfg_we) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                s_ready_s = fire_s | drop_s;
                if (fire_s || drop_s) begin
                    state_nxt_s = s_valid ? HOLD : IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            SETTLE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hold register: loaded on acceptance, keeps its last value otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_tag_r  <= '0;
            bus_data_r <= '0;
        end else if (accept_s) begin
            bus_tag_r  <= s_tag;
            bus_data_r <= s_data;
        end else begin
            bus_tag_r  <= bus_tag_r;
            bus_data_r <= bus_data_r;
        end
    end

    // Wait counter: restarts on every packet boundary, saturates while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_r <= '0;
        end else if (accept_s || fire_s || drop_s) begin
            wait_cnt_r <= '0;
        end else if (hold_valid_s && (wait_cnt_r != WAIT_MAX)) begin
            wait_cnt_r <= wait_cnt_r + WC_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky stall flag; setting beats a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_err_r <= 1'b0;
        end else if (hold_valid_s && !fire_s && !drop_s && (wait_cnt_r == WAIT_LAST)) begin
            stall_err_r <= 1'b1;
        end else if (err_clr) begin
            stall_err_r <= 1'b0;
        end else begin
            stall_err_r <= stall_err_r;
        end
    end

    // Delivered-packet counter and registered drop indication.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt_r    <= '0;
            drop_pulse_r <= 1'b0;
        end else begin
            pkt_cnt_r    <= pkt_cnt_r + PKT_CNT_W'(fire_s);
            drop_pulse_r <= drop_s;
        end
    end

    assign s_ready    = s_ready_s;
    assign cfg_ready  = cfg_ready_s;
    assign bus_en     = fire_s;
    assign bus_tag    = bus_tag_r;
    assign bus_data   = bus_data_r;
    assign drop_pulse = drop_pulse_r;
    assign stall_err  = stall_err_r;
    assign pkt_cnt    = pkt_cnt_r;

endmodule

// File: tb/tb_caster_bus_dispatcher.sv
// Self-checking bench for caster_bus_dispatcher: directed scenarios followed by
// random traffic, all compared each cycle against a packet-level reference model.
module tb_caster_bus_dispatcher;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int TW = 2;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [TW-1:0]     s_tag = '0;
    logic [DW-1:0]     s_data = '0;
    logic              cfg_we = 1'b0;
    logic [TW-1:0]     cfg_col = '0;
    logic [TW-1:0]     cfg_id = '0;
    logic              cfg_ready;
    logic [NC*TW-1:0]  id_out;
    logic [NC-1:0]     caster_ready = '1;
    logic              bus_en;
    logic [TW-1:0]     bus_tag;
    logic [DW-1:0]     bus_data;
    logic              drop_pulse;
    logic              stall_err;
    logic              err_clr = 1'b0;
    logic [15:0]       pkt_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one held packet, the ID table as an array, plain counters.
    bit m_held, m_settle, m_stall, m_drop;
    int m_tag, m_data, m_cnt, m_wt;
    int m_ids [NC];
    bit e_fire, e_drop, e_sready, e_cready;

    caster_bus_dispatcher #(
        .DATA_WIDTH (DW),
        .NUM_COL    (NC),
        .TAG_W      (TW),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_tag        (s_tag),
        .s_data       (s_data),
        .cfg_we       (cfg_we),
        .cfg_col      (cfg_col),
        .cfg_id       (cfg_id),
        .cfg_ready    (cfg_ready),
        .id_out       (id_out),
        .caster_ready (caster_ready),
        .bus_en       (bus_en),
        .bus_tag      (bus_tag),
        .bus_data     (bus_data),
        .drop_pulse   (drop_pulse),
        .stall_err    (stall_err),
        .err_clr      (err_clr),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_held = 1'b0; m_settle = 1'b0; m_stall = 1'b0; m_drop = 1'b0;
        m_tag = 0; m_data = 0; m_cnt = 0; m_wt = 0;
        for (int i = 0; i < NC; i++) m_ids[i] = i;
    endfunction

    // Which columns are targeted, and are all of them ready?
    function automatic void model_eval();
        int  hits = 0;
        int  blocked = 0;
        bit  idle;
        for (int c = 0; c < NC; c++) begin
            if (m_held && m_ids[c] == m_tag) begin
                hits++;
                if (!caster_ready[c]) blocked++;
            end
        end
        idle     = !m_held && !m_settle;
        e_fire   = (hits > 0) && (blocked == 0);
        e_drop   = m_held && (hits == 0);
        e_cready = idle;
        e_sready = (idle && !cfg_we) || (m_held && (e_fire || e_drop));
    endfunction

    function automatic void model_commit();
        bit idle = !m_held && !m_settle;
        bit acc  = s_valid && e_sready;
        bit wr   = cfg_we && idle && (int'(cfg_col) < NC);
        if (m_held && !e_fire && !e_drop && m_wt == TO - 1) m_stall = 1'b1;
        else if (err_clr) m_stall = 1'b0;
        if (acc || e_fire || e_drop) m_wt = 0;
        else if (m_held && m_wt < TO) m_wt++;
        m_cnt    = (m_cnt + int'(e_fire)) % 65536;
        m_drop   = e_drop;
        m_settle = wr;
        if (wr) m_ids[cfg_col] = int'(cfg_id);
        if (acc) begin
            m_held = 1'b1; m_tag = int'(s_tag); m_data = int'(s_data);
        end else if (e_fire || e_drop) begin
            m_held = 1'b0;
        end
    endfunction

    function automatic logic [31:0] model_ids_packed();
        logic [31:0] v = '0;
        int          id;
        for (int c = 0; c < NC; c++) begin
            id = m_ids[c];
            v[c*TW +: TW] = id[TW-1:0];
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: compare every output against the model, then advance the model.
    task automatic cycle();
        #1;
        model_eval();
        chk("bus_en",     32'(bus_en),     32'(e_fire));
        chk("s_ready",    32'(s_ready),    32'(e_sready));
        chk("cfg_ready",  32'(cfg_ready),  32'(e_cready));
        chk("bus_tag",    32'(bus_tag),    32'(m_tag));
        chk("bus_data",   32'(bus_data),   32'(m_data));
        chk("pkt_cnt",    32'(pkt_cnt),    32'(m_cnt));
        chk("stall_err",  32'(stall_err),  32'(m_stall));
        chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
        chk("id_out",     32'(id_out),     model_ids_packed());
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int col, input int id);
        cfg_we = 1'b1; cfg_col = TW'(col); cfg_id = TW'(id);
        cycle();
        cfg_we = 1'b0;
        #1 chk("settle_s_ready", 32'(s_ready), 32'd0);
        cycle();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_s_ready",   32'(s_ready),   32'd1);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_id_out",    32'(id_out),    32'h000000E4);

        // Unicast
        s_valid = 1'b1; s_tag = 2'd2; s_data = 16'hBEEF;
        cycle();
        s_valid = 1'b0;
        #1;
        chk("uni_bus_en",   32'(bus_en),   32'd1);
        chk("uni_bus_tag",  32'(bus_tag),  32'd2);
        chk("uni_bus_data", 32'(bus_data), 32'h0000BEEF);
        cycle();
        #1 chk("uni_cnt", 32'(pkt_cnt), 32'd1);

        // Multicast wait: columns 1 and 3 both carry ID 3
        cfg_write(1, 3);
        s_valid = 1'b1; s_tag = 2'd3; s_data = 16'h1234; caster_ready = 4'b0010;
        cycle();
        s_valid = 1'b0;
        repeat (3) cycle();
        #1 chk("mc_blocked", 32'(bus_en), 32'd0);
        caster_ready = 4'b1010;
        #1 chk("mc_fire", 32'(bus_en), 32'd1);
        cycle();
        #1 chk("mc_once", 32'(bus_en), 32'd0);
        cycle();

        // Streaming: 8 back-to-back packets, all ready
        caster_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_tag = (i % 2 == 1) ? 2'd2 : 2'd0; s_data = DW'(16'h0100 + i);
            cycle();
        end
        s_valid = 1'b0;
        cycle();
        #1 chk("stream_cnt", 32'(pkt_cnt), 32'd10);

        // Drop: no column carries ID 3
        cfg_write(1, 1);
        cfg_write(3, 0);
        s_valid = 1'b1; s_tag = 2'd3; s_data = 16'hDEAD;
        cycle();
        s_valid = 1'b0;
        cycle();
        #1 chk("drop_pulse_hi", 32'(drop_pulse), 32'd1);
        cycle();
        #1 chk("drop_cnt", 32'(pkt_cnt), 32'd10);

        // Timeout on tag 1 with nobody ready
        caster_ready = 4'b0000;
        s_valid = 1'b1; s_tag = 2'd1; s_data = 16'h5A5A;
        cycle();
        s_valid = 1'b0;
        repeat (15) cycle();
        #1 chk("to_not_yet", 32'(stall_err), 32'd0);
        cycle();
        #1 chk("to_set", 32'(stall_err), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        #1 chk("to_clr", 32'(stall_err), 32'd0);
        caster_ready = 4'b1111;
        #1 chk("to_deliver", 32'(bus_en), 32'd1);
        cycle();
        #1 chk("to_cnt", 32'(pkt_cnt), 32'd11);

        // Reset while holding a deliverable packet
        caster_ready = 4'b0000;
        s_valid = 1'b1; s_tag = 2'd2; s_data = 16'h7777;
        cycle();
        s_valid = 1'b0;
        caster_ready = 4'b1111;
        #1 chk("pre_rst_bus_en", 32'(bus_en), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_bus_en", 32'(bus_en), 32'd0);
        chk("mid_rst_id_out", 32'(id_out), 32'h000000E4);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        #1 chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        cycle();

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            s_valid      = 1'($urandom_range(0, 1));
            s_tag        = TW'($urandom_range(0, NC - 1));
            s_data       = DW'($urandom);
            caster_ready = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '1;
            cfg_we       = ($urandom_range(0, 15) == 0);
            cfg_col      = TW'($urandom_range(0, NC - 1));
            cfg_id       = TW'($urandom_range(0, NC - 1));
            err_clr      = ($urandom_range(0, 15) == 0);
            cycle();
        end
        s_valid = 1'b0; cfg_we = 1'b0; err_clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
